// File: rtl/lfsr_cfg_initiator.sv
// Bus initiator for the LFSR application register port: one command becomes
// poly/seed/CTRL writes, a stream of captured Q samples, then a STOP write.
module lfsr_cfg_initiator #(
   parameter int n = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [n-1:0] cmd_poly,
   input  logic [n-1:0] cmd_seed,
   input  logic [1:0]   cmd_mode,
   input  logic [7:0]   cmd_count,
   output logic [15:0]  A,
   output logic [n-1:0] D,
   output logic         W,
   input  logic [n-1:0] Q,
   output logic         smp_valid,
   output logic [n-1:0] smp_data,
   input  logic         smp_ready,
   output logic         busy,
   output logic         done
);

   localparam logic [15:0] ADDR_POLY = 16'h0010;
   localparam logic [15:0] ADDR_SEED = 16'h0012;
   localparam logic [15:0] ADDR_CTRL = 16'h0014;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_POLY,
      S_WR_SEED,
      S_WR_CTRL,
      S_CAPTURE,
      S_WR_STOP,
      S_DONE
   } state_e;

   state_e       state_q, state_d;
   logic [n-1:0] poly_q, poly_d;
   logic [n-1:0] seed_q, seed_d;
   logic [1:0]   mode_q, mode_d;
   logic [7:0]   count_q, count_d;
   logic [7:0]   rem_q, rem_d;
   logic [15:0]  a_q, a_d;
   logic [n-1:0] d_q, d_d;
   logic         w_q, w_d;
   logic         smp_valid_q, smp_valid_d;
   logic [n-1:0] smp_data_q, smp_data_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic         accept;
   logic [7:0]   rem_left;

   assign cmd_ready = (state_q == S_IDLE) && !reset;

   assign A         = a_q;
   assign D         = d_q;
   assign W         = w_q;
   assign smp_valid = smp_valid_q;
   assign smp_data  = smp_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

   // rem counts samples still owed downstream, including the one in the buffer.
   assign accept   = smp_valid_q && smp_ready;
   assign rem_left = rem_q - {7'd0, accept};

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      poly_d      = poly_q;
      seed_d      = seed_q;
      mode_d      = mode_q;
      count_d     = count_q;
      rem_d       = rem_q;
      a_d         = '0;
      d_d         = '0;
      w_d         = 1'b0;
      smp_valid_d = smp_valid_q;
      smp_data_d  = smp_data_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               poly_d  = cmd_poly;
               seed_d  = cmd_seed;
               mode_d  = cmd_mode;
               count_d = cmd_count;
               state_d = S_WR_POLY;
               w_d     = 1'b1;
               a_d     = ADDR_POLY;
               d_d     = cmd_poly;
            end
         end
         S_WR_POLY: begin
            state_d = S_WR_SEED;
            w_d     = 1'b1;
            a_d     = ADDR_SEED;
            d_d     = seed_q;
         end
         S_WR_SEED: begin
            state_d   = S_WR_CTRL;
            w_d       = 1'b1;
            a_d       = ADDR_CTRL;
            d_d[1:0]  = mode_q;
         end
         S_WR_CTRL: begin
            if (count_q != 8'd0) begin
               state_d = S_CAPTURE;
               rem_d   = count_q;
            end else begin
               state_d = S_WR_STOP;
               w_d     = 1'b1;
               a_d     = ADDR_CTRL;
            end
         end
         S_CAPTURE: begin
            if (accept) rem_d = rem_left;
            if ((!smp_valid_q || accept) && rem_left != 8'd0) begin
               smp_valid_d = 1'b1;
               smp_data_d  = Q;
            end else if (accept) begin
               smp_valid_d = 1'b0;
            end
            if (accept && rem_left == 8'd0) begin
               state_d = S_WR_STOP;
               w_d     = 1'b1;
               a_d     = ADDR_CTRL;
            end
         end
         S_WR_STOP: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         poly_q      <= '0;
         seed_q      <= '0;
         mode_q      <= '0;
         count_q     <= '0;
         rem_q       <= '0;
         a_q         <= '0;
         d_q         <= '0;
         w_q         <= 1'b0;
         smp_valid_q <= 1'b0;
         smp_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         poly_q      <= poly_d;
         seed_q      <= seed_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         rem_q       <= rem_d;
         a_q         <= a_d;
         d_q         <= d_d;
         w_q         <= w_d;
         smp_valid_q <= smp_valid_d;
         smp_data_q  <= smp_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_lfsr_cfg_initiator.sv
// Self-checking bench for lfsr_cfg_initiator: random Q and ready patterns, with
// expected per-cycle bus, stream and status values derived from the command timeline.
module tb_lfsr_cfg_initiator;

   localparam int NW   = 8;
   localparam int MAXC = 300;

   logic          clock = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [NW-1:0] cmd_poly;
   logic [NW-1:0] cmd_seed;
   logic [1:0]    cmd_mode;
   logic [7:0]    cmd_count;
   logic [15:0]   A;
   logic [NW-1:0] D;
   logic          W;
   logic [NW-1:0] Q;
   logic          smp_valid;
   logic [NW-1:0] smp_data;
   logic          smp_ready;
   logic          busy;
   logic          done;

   always #5 clock = ~clock;

   lfsr_cfg_initiator #(.n(NW)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_poly  (cmd_poly),
      .cmd_seed  (cmd_seed),
      .cmd_mode  (cmd_mode),
      .cmd_count (cmd_count),
      .A         (A),
      .D         (D),
      .W         (W),
      .Q         (Q),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .smp_ready (smp_ready),
      .busy      (busy),
      .done      (done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Per-cycle stimulus, indexed by cycle relative to the command handshake.
   logic [7:0]  q_pat     [MAXC];
   bit          ready_pat [MAXC];

   // Per-cycle observations.
   logic        w_o  [MAXC];
   logic [15:0] a_o  [MAXC];
   logic [7:0]  d_o  [MAXC];
   logic        v_o  [MAXC];
   logic [7:0]  sd_o [MAXC];
   logic        busy_o [MAXC];
   logic        done_o [MAXC];
   logic        cr_o [MAXC];

   // Expected: bus {W,A,D}, stream {valid,data}, status {busy,done,cmd_ready}.
   logic [24:0] exp_bus [MAXC];
   logic [8:0]  exp_str [MAXC];
   logic [2:0]  exp_ctl [MAXC];

   task automatic fill_patterns(input bit rand_ready);
      for (int i = 0; i < MAXC; i++) begin
         q_pat[i]     = 8'($urandom);
         ready_pat[i] = rand_ready ? (i >= 60 || $urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   // Reference timeline: sample k is presented from its first cycle until the
   // first ready cycle, carrying the Q seen the cycle before it appeared.
   task automatic model_build(input logic [7:0] poly, input logic [7:0] seed,
                              input logic [1:0] mode, input logic [7:0] cnt,
                              output int idle);
      int c, p, stop;
      for (int i = 0; i < MAXC; i++) begin
         exp_bus[i] = '0;
         exp_str[i] = '0;
         exp_ctl[i] = 3'b001;
      end
      exp_bus[1] = {1'b1, 16'h0010, poly};
      exp_bus[2] = {1'b1, 16'h0012, seed};
      exp_bus[3] = {1'b1, 16'h0014, 6'd0, mode};
      c = 5;
      for (int k = 0; k < int'(cnt); k++) begin
         p = c;
         while (!ready_pat[c] && c < MAXC - 4) c++;
         for (int j = p; j <= c; j++) exp_str[j] = {1'b1, q_pat[p-1]};
         c++;
      end
      stop = (cnt == 8'd0) ? 4 : c;
      exp_bus[stop] = {1'b1, 16'h0014, 8'h00};
      for (int j = 1; j <= stop; j++) exp_ctl[j] = 3'b100;
      exp_ctl[stop+1] = 3'b110;
      idle = stop + 2;
   endtask

   task automatic sample_and_drive(input int c);
      w_o[c]    = W;
      a_o[c]    = A;
      d_o[c]    = D;
      v_o[c]    = smp_valid;
      sd_o[c]   = smp_data;
      busy_o[c] = busy;
      done_o[c] = done;
      cr_o[c]   = cmd_ready;
      Q         = q_pat[c];
      smp_ready = ready_pat[c];
   endtask

   task automatic drive_cmd(input logic [7:0] poly, input logic [7:0] seed,
                            input logic [1:0] mode, input logic [7:0] cnt,
                            input int last);
      @(negedge clock);
      sample_and_drive(0);
      cmd_valid = 1'b1;
      cmd_poly  = poly;
      cmd_seed  = seed;
      cmd_mode  = mode;
      cmd_count = cnt;
      for (int c = 1; c <= last; c++) begin
         @(negedge clock);
         cmd_valid = 1'b0;
         sample_and_drive(c);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({cmd_ready, A, D, W, smp_valid, smp_data, busy, done} !== '0)
         $display("FAIL reset_outputs: got rdy=%b A=%h D=%h W=%b v=%b sd=%h busy=%b done=%b, expected all 0",
                  cmd_ready, A, D, W, smp_valid, smp_data, busy, done);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_config_sequence();
      int idle;
      fill_patterns(1'b0);
      model_build(8'd221, 8'd120, 2'b01, 8'd4, idle);
      drive_cmd(8'd221, 8'd120, 2'b01, 8'd4, idle + 1);
      for (int c = 0; c <= idle + 1; c++) begin
         n_checks++;
         if ({w_o[c], a_o[c], d_o[c]} !== exp_bus[c])
            $display("FAIL cfg_bus cycle %0d: got %h expected %h", c, {w_o[c], a_o[c], d_o[c]}, exp_bus[c]);
         else n_pass++;
         n_checks++;
         if ({v_o[c], v_o[c] ? sd_o[c] : 8'h00} !== exp_str[c])
            $display("FAIL cfg_stream cycle %0d: got %h expected %h", c, {v_o[c], sd_o[c]}, exp_str[c]);
         else n_pass++;
         n_checks++;
         if ({busy_o[c], done_o[c], cr_o[c]} !== exp_ctl[c])
            $display("FAIL cfg_status cycle %0d: got %b expected %b", c, {busy_o[c], done_o[c], cr_o[c]}, exp_ctl[c]);
         else n_pass++;
      end
   endtask

   task automatic test_zero_count();
      int idle;
      fill_patterns(1'b0);
      model_build(8'h5a, 8'hc3, 2'b10, 8'd0, idle);
      drive_cmd(8'h5a, 8'hc3, 2'b10, 8'd0, idle + 1);
      for (int c = 0; c <= idle + 1; c++) begin
         n_checks++;
         if ({w_o[c], a_o[c], d_o[c]} !== exp_bus[c])
            $display("FAIL zero_bus cycle %0d: got %h expected %h", c, {w_o[c], a_o[c], d_o[c]}, exp_bus[c]);
         else n_pass++;
         n_checks++;
         if (v_o[c] !== 1'b0)
            $display("FAIL zero_valid cycle %0d: got %b expected 0", c, v_o[c]);
         else n_pass++;
         n_checks++;
         if ({busy_o[c], done_o[c], cr_o[c]} !== exp_ctl[c])
            $display("FAIL zero_status cycle %0d: got %b expected %b", c, {busy_o[c], done_o[c], cr_o[c]}, exp_ctl[c]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int idle;
      int dc;
      int acc;
      fill_patterns(1'b0);
      for (int i = 5; i <= 9; i++) ready_pat[i] = 1'b0;
      model_build(8'h8e, 8'h01, 2'b11, 8'd3, idle);
      drive_cmd(8'h8e, 8'h01, 2'b11, 8'd3, idle + 1);
      dc  = -1;
      acc = 0;
      for (int c = 0; c <= idle + 1; c++) begin
         if (done_o[c] === 1'b1 && dc < 0) dc = c;
         if (v_o[c] === 1'b1 && ready_pat[c]) acc++;
         n_checks++;
         if ({w_o[c], a_o[c], d_o[c]} !== exp_bus[c])
            $display("FAIL bp_bus cycle %0d: got %h expected %h", c, {w_o[c], a_o[c], d_o[c]}, exp_bus[c]);
         else n_pass++;
         n_checks++;
         if ({v_o[c], v_o[c] ? sd_o[c] : 8'h00} !== exp_str[c])
            $display("FAIL bp_stream cycle %0d: got %h expected %h", c, {v_o[c], sd_o[c]}, exp_str[c]);
         else n_pass++;
      end
      n_checks++;
      if (dc !== 6 + 3 + 5) $display("FAIL bp_done_cycle: got %0d expected %0d", dc, 6 + 3 + 5);
      else n_pass++;
      n_checks++;
      if (acc !== 3) $display("FAIL bp_accepts: got %0d expected 3", acc);
      else n_pass++;
   endtask

   task automatic test_reset_mid_capture();
      fill_patterns(1'b0);
      drive_cmd(8'h33, 8'h44, 2'b01, 8'd6, 7);
      for (int c = 5; c <= 6; c++) begin
         n_checks++;
         if ({v_o[c], sd_o[c]} !== {1'b1, q_pat[c-1]})
            $display("FAIL rst_mid_sample cycle %0d: got %h expected %h", c, {v_o[c], sd_o[c]}, {1'b1, q_pat[c-1]});
         else n_pass++;
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({W, smp_valid, busy, done, cmd_ready, A, D, smp_data} !== '0)
         $display("FAIL rst_mid_outputs: got W=%b v=%b busy=%b done=%b rdy=%b A=%h D=%h sd=%h expected all 0",
                  W, smp_valid, busy, done, cmd_ready, A, D, smp_data);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         n_checks++;
         if ({W, busy, A} !== '0)
            $display("FAIL rst_mid_no_stop cycle %0d: got W=%b busy=%b A=%h expected 0", c, W, busy, A);
         else n_pass++;
      end
   endtask

   task automatic test_busy_lockout();
      logic [7:0] fp [16];
      logic [7:0] fs [16];
      logic [1:0] fm [16];
      fill_patterns(1'b0);
      @(negedge clock);
      sample_and_drive(0);
      fp[0] = 8'($urandom);
      fs[0] = 8'($urandom);
      fm[0] = 2'($urandom);
      cmd_valid = 1'b1;
      cmd_poly  = fp[0];
      cmd_seed  = fs[0];
      cmd_mode  = fm[0];
      cmd_count = 8'd2;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         sample_and_drive(c);
         fp[c] = 8'($urandom);
         fs[c] = 8'($urandom);
         fm[c] = 2'($urandom);
         cmd_poly  = fp[c];
         cmd_seed  = fs[c];
         cmd_mode  = fm[c];
         cmd_count = 8'($urandom);
      end
      cmd_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         n_checks++;
         if (cr_o[c] !== (c == 9))
            $display("FAIL lock_ready cycle %0d: got %b expected %b", c, cr_o[c], c == 9);
         else n_pass++;
      end
      n_checks++;
      if (done_o[8] !== 1'b1) $display("FAIL lock_done: got %b expected 1", done_o[8]);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         int b;
         int f;
         b = (k == 0) ? 1 : 10;
         f = (k == 0) ? 0 : 9;
         n_checks++;
         if ({w_o[b], a_o[b], d_o[b]} !== {1'b1, 16'h0010, fp[f]})
            $display("FAIL lock_poly cmd %0d: got %h expected %h", k, {w_o[b], a_o[b], d_o[b]}, {1'b1, 16'h0010, fp[f]});
         else n_pass++;
         n_checks++;
         if ({w_o[b+1], a_o[b+1], d_o[b+1]} !== {1'b1, 16'h0012, fs[f]})
            $display("FAIL lock_seed cmd %0d: got %h expected %h", k, {w_o[b+1], a_o[b+1], d_o[b+1]}, {1'b1, 16'h0012, fs[f]});
         else n_pass++;
         n_checks++;
         if ({w_o[b+2], a_o[b+2], d_o[b+2]} !== {1'b1, 16'h0014, 6'd0, fm[f]})
            $display("FAIL lock_ctrl cmd %0d: got %h expected %h", k, {w_o[b+2], a_o[b+2], d_o[b+2]}, {1'b1, 16'h0014, 6'd0, fm[f]});
         else n_pass++;
      end
      do_reset();
   endtask

   task automatic test_random();
      int idle;
      logic [7:0] poly, seed, cnt;
      logic [1:0] mode;
      for (int it = 0; it < 6; it++) begin
         poly = 8'($urandom);
         seed = 8'($urandom);
         mode = 2'($urandom);
         cnt  = (it == 0) ? 8'd255 : 8'($urandom_range(0, 20));
         fill_patterns(it != 0);
         model_build(poly, seed, mode, cnt, idle);
         drive_cmd(poly, seed, mode, cnt, idle + 1);
         for (int c = 0; c <= idle + 1; c++) begin
            n_checks++;
            if ({w_o[c], a_o[c], d_o[c]} !== exp_bus[c])
               $display("FAIL rnd%0d_bus cycle %0d: got %h expected %h", it, c, {w_o[c], a_o[c], d_o[c]}, exp_bus[c]);
            else n_pass++;
            n_checks++;
            if ({v_o[c], v_o[c] ? sd_o[c] : 8'h00} !== exp_str[c])
               $display("FAIL rnd%0d_stream cycle %0d: got %h expected %h", it, c, {v_o[c], sd_o[c]}, exp_str[c]);
            else n_pass++;
            n_checks++;
            if ({busy_o[c], done_o[c], cr_o[c]} !== exp_ctl[c])
               $display("FAIL rnd%0d_status cycle %0d: got %b expected %b", it, c, {busy_o[c], done_o[c], cr_o[c]}, exp_ctl[c]);
            else n_pass++;
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_poly  = '0;
      cmd_seed  = '0;
      cmd_mode  = '0;
      cmd_count = '0;
      Q         = '0;
      smp_ready = 1'b0;
      test_reset();
      test_config_sequence();
      test_zero_count();
      test_backpressure();
      test_reset_mid_capture();
      test_busy_lockout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lfsr_cfg_initiator.md
# lfsr_cfg_initiator

- Bus initiator for the LFSR `application` block's register port (`A`/`D`/`W`/`Q`).
- Takes one configuration command over a valid/ready handshake and writes the polynomial, seed and CTRL registers in order.
- Streams a requested number of `Q` samples out over a valid/ready interface, then writes CTRL back to STOP.
- Replaces hand-written bench and host write sequences as the driver sitting in front of `application`.

## Interface

Parameters:
- `n`, default 8: LFSR width; width of `D`, `Q`, polynomial, seed and sample data.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: initiator can accept a command.
- `cmd_poly`  in  n: polynomial value, written to address 16'h0010.
- `cmd_seed`  in  n: seed value, written to address 16'h0012.
- `cmd_mode`  in  2: CTRL mode, written to `D[1:0]` at address 16'h0014. 2'b00 means STOP.
- `cmd_count`  in  8: number of `Q` samples to deliver (0–255).
- `A`  out  16: register address to `application`.
- `D`  out  n: write data to `application`.
- `W`  out  1: write strobe to `application`.
- `Q`  in  n: LFSR output from `application`.
- `smp_valid`  out  1: sample present on `smp_data`.
- `smp_data`  out  n: captured `Q` value.
- `smp_ready`  in  1: downstream accepts the sample.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse marking the end of a command.

## Operation

- FSM states: IDLE → WR_POLY → WR_SEED → WR_CTRL → CAPTURE → WR_STOP → DONE → IDLE.
- IDLE
  - `cmd_ready` = 1 (forced 0 while `reset` is high).
  - When `cmd_valid & cmd_ready`: latch poly, seed, mode and count into internal registers; go to WR_POLY.
  - Inputs are ignored outside this handshake.
- Register writes: each write state lasts exactly one cycle with `W`=1.
  - WR_POLY: `A`=16'h0010, `D`=poly.
  - WR_SEED: `A`=16'h0012, `D`=seed.
  - WR_CTRL: `A`=16'h0014, `D`={(n-2) zeros, mode}.
  - WR_STOP: `A`=16'h0014, `D`=0.
- Bus idle value: whenever `W`=0, `A`=16'h0000 and `D`=0.
- WR_CTRL exits to CAPTURE if the latched count is nonzero; if count = 0 it exits directly to WR_STOP.
- CAPTURE uses a one-entry output buffer and a remaining-sample counter, `rem`, loaded with count.
  - On any cycle where the buffer is empty, or is full and being accepted (`smp_valid & smp_ready`), and `rem` > 0 not counting that accept: load `Q` into `smp_data` and set `smp_valid`.
  - Each accept decrements `rem`.
  - When the accept takes `rem` to 0: clear `smp_valid` and go to WR_STOP.
  - While `smp_valid & ~smp_ready`, `smp_data` holds stable. `Q` values presented during a stall are dropped.
  - Samples are therefore consecutive LFSR states only while `smp_ready` is held high.
- DONE: `done`=1 for one cycle, then return to IDLE. `busy` is still 1 in DONE.
- Reset (any state, including mid-write or mid-capture):
  - Next edge forces IDLE; `W`, `smp_valid`, `done`, `busy` = 0; `A`, `D`, `smp_data` = 0; all counters cleared.
  - No STOP write is issued. CTRL in `application` is left in whatever state it was last written to.

## Timing

Cycle 0 is the cycle in which the command handshake completes.

- Cycles 1, 2, 3: WR_POLY, WR_SEED, WR_CTRL, each with `W`=1.
- Cycle 4: first CAPTURE cycle; `Q` is loaded at the end of this cycle.
- Cycle 5: first `smp_valid`=1.
- With `smp_ready` held high: one sample per cycle on cycles 5 through 4+N.
  - WR_STOP on cycle 5+N, `done` on cycle 6+N, `cmd_ready`=1 again on cycle 7+N.
  - Each stall cycle pushes all of the above later by one.
- N = 0: WR_STOP on cycle 4, `done` on cycle 5, `cmd_ready` on cycle 6.
- `cmd_ready` is 0 from cycle 1 until return to IDLE. A new `cmd_valid` is never accepted back-to-back with `done`.
- Output values at reset: `cmd_ready`=0 while `reset`=1; `A`=0, `D`=0, `W`=0, `smp_valid`=0, `smp_data`=0, `busy`=0, `done`=0.

## Test plan

1. **Configuration sequence.** Reset, then command poly=221, seed=120, mode=2'b01, count=4, `smp_ready`=1.
   - Required: writes (16'h0010,221), (16'h0012,120), (16'h0014,1) on cycles 1–3.
   - Required: 4 samples equal to `Q` sampled on cycles 4–7; STOP write (16'h0014,0); one `done` pulse.
2. **Zero count.** count=0.
   - Required: three config writes, STOP write on cycle 4, `done` on cycle 5, `smp_valid` never 1.
3. **Backpressure.** count=3, `smp_ready` low for 5 cycles after the first `smp_valid`.
   - Required: `smp_data` stable while stalled; exactly 3 accepts; `done` delayed by 5 cycles versus scenario 1's timing.
4. **Reset mid-capture.** Assert `reset` after the second accept of a count=6 command.
   - Required: next cycle `W`=0, `smp_valid`=0, `busy`=0; no STOP write; `cmd_ready`=1 after `reset` drops.
5. **Busy lockout.** Hold `cmd_valid`=1 continuously with changing fields.
   - Required: a second command is accepted only on the first IDLE cycle after `done`, and its latched fields are those present in that cycle.
